// File: rtl/alu_pwr_pkg.sv
// Shared state encoding for the ALU power sequencer.
package alu_pwr_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StOff   = 3'd0,
    StPwrUp = 3'd1,
    StOn    = 3'd2,
    StDrain = 3'd3,
    StIsoOn = 3'd4
  } pwr_state_e;

endpackage

// File: rtl/alu_pwr_timer.sv
// 8-bit dwell counter: loads a value, counts down to zero, flags done at count==1.
module alu_pwr_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != 8'd0) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign done = (count_q == 8'd1);

endmodule

// File: rtl/alu_pwr_seq.sv
// Power-state sequencer for the gated ALU: orders isolation and power switching,
// wakes on demand and powers down on idle timeout or sleep request.
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int unsigned PWRUP_CYC    = 4,
  parameter int unsigned ISO_CYC      = 2,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  output logic              alu_start,
  input  logic              alu_busy,
  input  logic              wake_req,
  input  logic              sleep_req,
  output logic              alu_pwr_en,
  output logic              iso_en,
  output logic [StateW-1:0] pwr_state
);

  localparam logic [15:0] IdleMax  = 16'(IDLE_TIMEOUT);
  localparam logic [7:0]  PwrupVal = 8'(PWRUP_CYC);
  localparam logic [7:0]  IsoVal   = 8'(ISO_CYC);

  logic [StateW-1:0] state_q;
  logic              start_q;
  logic [15:0]       idle_q;
  logic              wake_go;
  logic              iso_go;
  logic              idle_hit;
  logic              timer_load;
  logic [7:0]        timer_val;
  logic              timer_done;

  always_comb begin
    op_ready   = (state_q == StOn) & ~alu_busy & ~start_q & ~sleep_req;
    alu_start  = op_valid & op_ready;
    wake_go    = (op_valid | wake_req) & ~sleep_req;
    // start_q covers the gap before the ALU raises busy for a fresh op
    iso_go     = ~alu_busy & ~start_q;
    idle_hit   = (IDLE_TIMEOUT != 0) && (idle_q == IdleMax) && !op_valid;
    timer_load = ((state_q == StOff) && wake_go) ||
                 ((state_q == StDrain) && !wake_go && iso_go);
    timer_val  = (state_q == StOff) ? PwrupVal : IsoVal;
  end

  alu_pwr_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StOff;
      alu_pwr_en <= 1'b0;
      iso_en     <= 1'b1;
      start_q    <= 1'b0;
      idle_q     <= 16'd0;
    end else begin
      start_q <= alu_start;
      idle_q  <= 16'd0;
      case (state_q)
        StOff: begin
          if (wake_go) begin
            state_q    <= StPwrUp;
            alu_pwr_en <= 1'b1;
          end
        end
        StPwrUp: begin
          if (timer_done) begin
            state_q <= StOn;
            iso_en  <= 1'b0;
          end
        end
        StOn: begin
          if (alu_start | alu_busy | start_q) begin
            idle_q <= 16'd0;
          end else if (idle_q != IdleMax) begin
            idle_q <= idle_q + 16'd1;
          end else begin
            idle_q <= idle_q;
          end
          if (sleep_req | idle_hit) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (wake_go) begin
            state_q <= StOn;
          end else if (iso_go) begin
            state_q <= StIsoOn;
            iso_en  <= 1'b1;
          end
        end
        StIsoOn: begin
          if (timer_done) begin
            state_q    <= StOff;
            alu_pwr_en <= 1'b0;
          end
        end
        default: begin
          state_q    <= StOff;
          alu_pwr_en <= 1'b0;
          iso_en     <= 1'b1;
        end
      endcase
    end
  end

  assign pwr_state = state_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed bench for alu_pwr_seq with default parameters (PWRUP 4, ISO 2, IDLE 16).
module tb_alu_pwr_seq;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic       alu_start;
  logic       alu_busy;
  logic       wake_req;
  logic       sleep_req;
  logic       alu_pwr_en;
  logic       iso_en;
  logic [2:0] pwr_state;

  int vectors     = 0;
  int miscompares = 0;
  int starts_seen = 0;

  // {pwr_state, alu_pwr_en, iso_en, op_ready, alu_start}
  localparam logic [6:0] XOff     = 7'b000_0_1_0_0;
  localparam logic [6:0] XPwrUp   = 7'b001_1_1_0_0;
  localparam logic [6:0] XOnRdy   = 7'b010_1_0_1_0;
  localparam logic [6:0] XOnStart = 7'b010_1_0_1_1;
  localparam logic [6:0] XOnBlk   = 7'b010_1_0_0_0;
  localparam logic [6:0] XDrain   = 7'b011_1_0_0_0;
  localparam logic [6:0] XIso     = 7'b100_1_1_0_0;

  alu_pwr_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .alu_start  (alu_start),
    .alu_busy   (alu_busy),
    .wake_req   (wake_req),
    .sleep_req  (sleep_req),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .pwr_state  (pwr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Isolation may only drop while the ALU is powered.
  always @(negedge clk) begin
    vectors++;
    assert (iso_en !== 1'b0 || alu_pwr_en === 1'b1) else begin
      miscompares++;
      $error("FAIL invariant: observed iso_en=%b alu_pwr_en=%b expected alu_pwr_en=1",
             iso_en, alu_pwr_en);
    end
  end

  // Check the current cycle at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    @(negedge clk);
    obs = {pwr_state, alu_pwr_en, iso_en, op_ready, alu_start};
    if (alu_start === 1'b1) starts_seen++;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    alu_busy  = 1'b0;
    wake_req  = 1'b0;
    sleep_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    step("reset", XOff);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step("idle_off", XOff);

    // On-demand wake from OFF
    op_valid = 1'b1;
    step("wake_c0", XOff);
    for (int i = 0; i < 4; i++) step("pwrup", XPwrUp);
    step("op1_start", XOnStart);
    alu_busy = 1'b1;
    for (int i = 0; i < 3; i++) step("op2_blocked", XOnBlk);
    alu_busy = 1'b0;
    step("op2_start", XOnStart);
    op_valid = 1'b0;
    alu_busy = 1'b1;
    for (int i = 0; i < 3; i++) step("op2_busy", XOnBlk);
    alu_busy = 1'b0;

    // Idle timeout: count 0..16 across 17 ON cycles, then drain and isolate
    for (int i = 0; i < 17; i++) step("idle_on", XOnRdy);
    step("idle_drain", XDrain);
    step("iso_1", XIso);
    step("iso_2", XIso);
    wake_req = 1'b1;
    step("off_after_iso", XOff);
    wake_req = 1'b0;
    for (int i = 0; i < 4; i++) step("pwrup2", XPwrUp);

    // Sleep into DRAIN, then abort with an op
    sleep_req = 1'b1;
    step("on_sleep", XOnBlk);
    sleep_req = 1'b0;
    op_valid  = 1'b1;
    step("drain_abort", XDrain);
    step("abort_start", XOnStart);
    op_valid = 1'b0;
    step("abort_startq", XOnBlk);

    // Sleep again; wake arrives during ISO_ON and is honoured from OFF
    sleep_req = 1'b1;
    step("on_sleep2", XOnBlk);
    step("drain2", XDrain);
    sleep_req = 1'b0;
    wake_req  = 1'b1;
    step("iso_wake_1", XIso);
    step("iso_wake_2", XIso);
    step("off_late_wake", XOff);
    wake_req = 1'b0;
    for (int i = 0; i < 4; i++) step("pwrup_late", XPwrUp);
    step("on_pre_rst", XOnRdy);

    // Reset while ON
    rst_n = 1'b0;
    step("on_in_rst", XOnRdy);
    rst_n = 1'b1;
    step("rst_off", XOff);

    // Sleep beats wake and op in OFF
    sleep_req = 1'b1;
    wake_req  = 1'b1;
    for (int i = 0; i < 3; i++) step("sleep_wins_off", XOff);
    op_valid = 1'b1;
    step("sleep_wins_op", XOff);
    sleep_req = 1'b0;
    op_valid  = 1'b0;
    step("wake_off", XOff);
    wake_req = 1'b0;
    step("pwrup_after_prio", XPwrUp);

    vectors++;
    assert (starts_seen === 3) else begin
      miscompares++;
      $error("FAIL start_count: observed %0d expected 3", starts_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
